if_stage: RTL

- Instruction-fetch stage. Generates the program counter and drives the instruction ROM's chip-enable and address.
- Registers the fetched {pc, inst} pair into the IF/ID pipeline outputs consumed by the decode stage.
- Handles pipeline stalls, branch redirects from decode, and exception flushes from the control unit.
- Sits directly upstream of the instruction ROM (addr/ce) and directly downstream of it (inst).

---
 rtl/if_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, ROM chip-enable/address and IF/ID register.
// Optional fetch alignment check (AdEL) enabled by defining IF_ADDR_ERR_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic [31:0] rom_inst_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] if_excepttype_o
);

    logic        ce_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        unused_stall;

    assign unused_stall = ^stall[5:3];
    assign rom_addr_o   = pc_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;

`ifdef IF_ADDR_ERR_EN
    logic        addr_err;
    logic [31:0] exc_q, exc_d;

    // A misaligned PC suppresses the ROM access and is reported to decode as AdEL.
    assign addr_err        = ce_q && (pc_q[1:0] != 2'b00);
    assign rom_ce_o        = ce_q && !addr_err;
    assign if_excepttype_o = exc_q;
`else
    assign rom_ce_o        = ce_q;
    assign if_excepttype_o = 32'h0000_0000;
`endif

    always_comb begin
        pc_d = pc_q;
        if (!ce_q)                pc_d = RESET_PC;
        else if (flush)           pc_d = new_pc;
        else if (stall[0])        pc_d = pc_q;
        else if (branch_flag_i)   pc_d = branch_target_address_i;
        else                      pc_d = pc_q + PC_STEP;
    end

    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
`ifdef IF_ADDR_ERR_EN
        exc_d     = exc_q;
`endif
        if (!ce_q) begin
            id_pc_d   = RESET_PC;
            id_inst_d = 32'h0000_0000;
`ifdef IF_ADDR_ERR_EN
            exc_d     = 32'h0000_0000;
`endif
        end else if (flush || (stall[1] && !stall[2])) begin
            id_pc_d   = 32'h0000_0000;
            id_inst_d = 32'h0000_0000;
`ifdef IF_ADDR_ERR_EN
            exc_d     = 32'h0000_0000;
`endif
        end else if (!stall[1]) begin
            id_pc_d   = pc_q;
`ifdef IF_ADDR_ERR_EN
            id_inst_d = addr_err ? 32'h0000_0000 : rom_inst_i;
            exc_d     = addr_err ? 32'h0000_0010 : 32'h0000_0000;
`else
            id_inst_d = rom_inst_i;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q      <= 1'b0;
            pc_q      <= RESET_PC;
            id_pc_q   <= 32'h0000_0000;
            id_inst_q <= 32'h0000_0000;
`ifdef IF_ADDR_ERR_EN
            exc_q     <= 32'h0000_0000;
`endif
        end else begin
            ce_q      <= 1'b1;
            pc_q      <= pc_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
`ifdef IF_ADDR_ERR_EN
            exc_q     <= exc_d;
`endif
        end
    end

endmodule
